round_rr_share: RTL and testbench

ROUND_RR_SHARE -- requirements
Module: round_rr_share

---
 rtl/round_rr_share.sv | 92 +++++++++
 tb/tb_round_rr_share.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_rr_share.sv
// round_rr_share
//   Two requesters share one round-half-to-even rounding stage. A two-way
//   round-robin arbiter picks a requester, the winner's value is rounded
//   (NBITS LSBs removed), and the result is registered with one cycle of
//   latency. The output register drains and refills in the same cycle, so
//   the block sustains one result per cycle.
//
// Parameters
//   DIN    data width of both inputs and the output
//   NBITS  number of LSBs removed by rounding (2 <= NBITS < DIN)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   din0_valid/data/ready    requester 0 handshake
//   din1_valid/data/ready    requester 1 handshake
//   dout_valid/data/src      registered rounded result and its requester
//   dout_ready               consumer accepts dout
module round_rr_share #(
   parameter int DIN   = 16,
   parameter int NBITS = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           din0_valid,
   input  logic [DIN-1:0] din0_data,
   output logic           din0_ready,
   input  logic           din1_valid,
   input  logic [DIN-1:0] din1_data,
   output logic           din1_ready,
   output logic           dout_valid,
   output logic [DIN-1:0] dout_data,
   output logic           dout_src,
   input  logic           dout_ready
);

   logic           lg;        // index of the last granted requester
   logic           slot_free;
   logic           grant0;
   logic           grant1;
   logic           xfer;
   logic           sel;
   logic [DIN-1:0] sel_data;
   logic [DIN-1:0] rounded;

   // Round-half-to-even: increment the kept part when the removed part is
   // above half (R & S), or exactly half and the kept LSB is odd (R & L).
   function automatic logic [DIN-1:0] round_rne(input logic [DIN-1:0] d);
      logic           l;
      logic           r;
      logic           s;
      logic [DIN-1:0] q;
      l = d[NBITS];
      r = d[NBITS-1];
      s = |d[NBITS-2:0];
      q = (d >> NBITS) + {{(DIN-1){1'b0}}, (r & (s | l))};
      // Shift drops any carry out of the MSB, giving modulo 2^DIN wrap.
      return q << NBITS;
   endfunction

   assign slot_free = ~dout_valid | dout_ready;

   // With both requesting, the one not granted last time wins.
   assign grant0 = din0_valid & (~din1_valid | lg);
   assign grant1 = din1_valid & (~din0_valid | ~lg);

   assign din0_ready = ~rst & slot_free & grant0;
   assign din1_ready = ~rst & slot_free & grant1;

   assign xfer     = din0_ready | din1_ready;
   assign sel      = din1_ready;
   assign sel_data = sel ? din1_data : din0_data;
   assign rounded  = round_rne(sel_data);

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_valid <= 1'b0;
         dout_data  <= '0;
         dout_src   <= 1'b0;
         lg         <= 1'b1;
      end else if (xfer) begin
         // Covers both the empty-slot load and the drain-and-refill case.
         dout_valid <= 1'b1;
         dout_data  <= rounded;
         dout_src   <= sel;
         lg         <= sel;
      end else if (dout_ready) begin
         // Drained with nothing new: data and src keep their last values.
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_round_rr_share.sv
// tb_round_rr_share
//   Directed checks of reset, rounding, wrap, contention, backpressure and
//   mid-stream reset, followed by a random-traffic phase against a
//   reference model with an independent rounding formulation.
module tb_round_rr_share;

   logic        clk = 1'b0;
   logic        rst;
   logic        din0_valid, din1_valid;
   logic [15:0] din0_data, din1_data;
   logic        din0_ready, din1_ready;
   logic        dout_valid;
   logic [15:0] dout_data;
   logic        dout_src;
   logic        dout_ready;

   int total = 0;
   int bad   = 0;

   round_rr_share #(.DIN(16), .NBITS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .din0_valid (din0_valid),
      .din0_data  (din0_data),
      .din0_ready (din0_ready),
      .din1_valid (din1_valid),
      .din1_data  (din1_data),
      .din1_ready (din1_ready),
      .dout_valid (dout_valid),
      .dout_data  (dout_data),
      .dout_src   (dout_src),
      .dout_ready (dout_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference rounding written as quotient/remainder on integers.
   function automatic logic [15:0] rref(input logic [15:0] d);
      int q, r, t;
      q = int'(d) / 16;
      r = int'(d) % 16;
      if (r > 8 || (r == 8 && (q % 2) == 1)) q++;
      t = (q * 16) % 65536;
      return 16'(t);
   endfunction

   logic [15:0] rvec_in  [4] = '{16'h0018, 16'h0008, 16'h0009, 16'h0027};
   logic [15:0] rvec_out [4] = '{16'h0020, 16'h0000, 16'h0010, 16'h0020};
   logic [15:0] wvec_in  [2] = '{16'hFFF8, 16'hFFF7};
   logic [15:0] wvec_out [2] = '{16'h0000, 16'hFFF0};

   // random-phase model state
   logic        m_valid, m_src, m_lg;
   logic [15:0] m_data;
   logic        free, g0, g1, e0, e1;
   int          wait0, wait1;

   initial begin
      rst = 1'b1; din0_valid = 1'b1; din1_valid = 1'b1;
      din0_data = 16'h1234; din1_data = 16'h5678; dout_ready = 1'b1;
      #2;
      chk("rst_ready0", din0_ready, 0);
      chk("rst_ready1", din1_ready, 0);
      step();
      step();
      chk("rst_valid", dout_valid, 0);
      chk("rst_data",  dout_data,  16'h0000);
      chk("rst_src",   dout_src,   0);
      din0_valid = 1'b0; din1_valid = 1'b0;
      rst = 1'b0;
      step();

      // rounding vectors on requester 0
      for (int i = 0; i < 4; i++) begin
         din0_valid = 1'b1; din0_data = rvec_in[i];
         #1;
         chk($sformatf("rnd%0d_ready", i), din0_ready, 1);
         step();
         din0_valid = 1'b0;
         chk($sformatf("rnd%0d_valid", i), dout_valid, 1);
         chk($sformatf("rnd%0d_data", i),  dout_data,  rvec_out[i]);
         chk($sformatf("rnd%0d_src", i),   dout_src,   0);
      end
      step();
      chk("drain_valid", dout_valid, 0);
      chk("drain_data",  dout_data,  16'h0020);

      // wrap vectors on requester 1
      for (int i = 0; i < 2; i++) begin
         din1_valid = 1'b1; din1_data = wvec_in[i];
         step();
         din1_valid = 1'b0;
         chk($sformatf("wrap%0d_data", i), dout_data, wvec_out[i]);
         chk($sformatf("wrap%0d_src", i),  dout_src,  1);
      end
      step();

      // contention right after reset: grants 0,1,0,1
      rst = 1'b1; step(); rst = 1'b0;
      din0_valid = 1'b1; din1_valid = 1'b1;
      din0_data = 16'h0100; din1_data = 16'h0200; dout_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("cont%0d_r0", i), din0_ready, (i % 2 == 0));
         chk($sformatf("cont%0d_r1", i), din1_ready, (i % 2 == 1));
         step();
         chk($sformatf("cont%0d_valid", i), dout_valid, 1);
         chk($sformatf("cont%0d_src", i),   dout_src,   i % 2);
         chk($sformatf("cont%0d_data", i),  dout_data,  (i % 2) ? 16'h0200 : 16'h0100);
      end

      // backpressure with both valid
      dout_ready = 1'b0;
      din0_data = 16'h0118; din1_data = 16'h0227;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp%0d_r0", i), din0_ready, 0);
         chk($sformatf("bp%0d_r1", i), din1_ready, 0);
         step();
         chk($sformatf("bp%0d_valid", i), dout_valid, 1);
         chk($sformatf("bp%0d_data", i),  dout_data,  16'h0200);
      end
      dout_ready = 1'b1;
      #1;
      chk("rel0_r0", din0_ready, 1);
      step();
      chk("rel0_data", dout_data, 16'h0120);
      chk("rel0_src",  dout_src,  0);
      din0_data = 16'h0138;
      #1;
      chk("rel1_r1", din1_ready, 1);
      step();
      chk("rel1_data", dout_data, 16'h0220);
      chk("rel1_src",  dout_src,  1);
      #1;
      chk("rel2_r0", din0_ready, 1);
      step();
      chk("rel2_data", dout_data, 16'h0140);
      chk("rel2_src",  dout_src,  0);

      // reset while holding a result under backpressure
      dout_ready = 1'b0;
      step();
      chk("mid_held", dout_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_r0", din0_ready, 0);
      chk("mid_rst_r1", din1_ready, 0);
      step();
      rst = 1'b0;
      chk("mid_valid", dout_valid, 0);
      chk("mid_data",  dout_data,  16'h0000);
      dout_ready = 1'b1;
      #1;
      chk("mid_first_r0", din0_ready, 1);
      chk("mid_first_r1", din1_ready, 0);
      step();
      chk("mid_first_src", dout_src, 0);

      // random traffic against the model
      din0_valid = 1'b0; din1_valid = 1'b0; dout_ready = 1'b1;
      rst = 1'b1; step(); rst = 1'b0;
      m_valid = 1'b0; m_src = 1'b0; m_lg = 1'b1; m_data = '0;
      wait0 = 0; wait1 = 0;
      e0 = 1'b0; e1 = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         if (!din0_valid || e0) begin
            din0_valid = ($urandom_range(3) != 0);
            din0_data  = 16'($urandom);
         end
         if (!din1_valid || e1) begin
            din1_valid = ($urandom_range(3) != 0);
            din1_data  = 16'($urandom);
         end
         dout_ready = ($urandom_range(3) != 0);
         #1;
         free = !m_valid || dout_ready;
         g0 = din0_valid && (!din1_valid || m_lg);
         g1 = din1_valid && (!din0_valid || !m_lg);
         e0 = g0 && free;
         e1 = g1 && free;
         if (din0_ready !== e0 || din1_ready !== e1) begin
            chk("rnd_ready0", din0_ready, e0);
            chk("rnd_ready1", din1_ready, e1);
         end
         wait0 = (din0_valid && free && !din0_ready) ? wait0 + 1 : 0;
         wait1 = (din1_valid && free && !din1_ready) ? wait1 + 1 : 0;
         if (wait0 > 1 || wait1 > 1) chk("rnd_starve", 1, 0);
         if (e0 || e1) begin
            m_valid = 1'b1;
            m_src   = e1;
            m_lg    = e1;
            m_data  = rref(e1 ? din1_data : din0_data);
         end else if (dout_ready) begin
            m_valid = 1'b0;
         end
         step();
         if (dout_valid !== m_valid || dout_data !== m_data || dout_src !== m_src) begin
            chk("rnd_valid", dout_valid, m_valid);
            chk("rnd_data",  dout_data,  m_data);
            chk("rnd_src",   dout_src,   m_src);
         end else begin
            total++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
